mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Memory-access (MEM) stage sitting directly upstream of the 8-entry data memory.
- Accepts load/store requests from execute over a valid/ready handshake and drives the data memory's combinational-read / clocked-write port.
- Returns load results to writeback over a second valid/ready handshake.
- Flags out-of-range addresses so the memory's address aliasing never reaches the architecture.

Parameters:
- DATA_W, 8, data width of memory word and register value
- ADDR_W, 8, width of the request address
- DEPTH_LOG2, 3, log2 of implemented memory depth; valid addresses are 0..2**DEPTH_LOG2-1
- RIDX_W, 3, destination register index width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  execute presents a request
- req_ready  out  1  stage can accept a request
- req_op  in  1  0 = load, 1 = store
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data
- req_rd  in  RIDX_W  load destination register
- rom_address  out  ADDR_W  to memory
- rom_write_data  out  DATA_W  to memory
- rom_write  out  1  memory write enable, sampled by memory at posedge
- rom_read  out  1  memory read enable; memory returns 0 when low
- rom_data  in  DATA_W  combinational read data from memory
- rsp_valid  out  1  response available
- rsp_ready  in  1  writeback accepts response
- rsp_is_load  out  1  response belongs to a load (write register file)
- rsp_rd  out  RIDX_W  destination register
- rsp_data  out  DATA_W  load data; 0 for stores and faults
- rsp_fault  out  1  address out of range

Behaviour:
- FSM states: IDLE, ACCESS, RESP. State, request and response registers all update on posedge clk.
- Reset (rst high at an edge): state becomes IDLE. All registered outputs clear: rsp_valid, rsp_is_load, rsp_rd, rsp_data, rsp_fault, and the latched op/addr/wdata/rd all go to 0. rom_read and rom_write are also forced to 0 combinationally while rst is high.
- req_ready is 1 only in IDLE and when rst is low.
- IDLE:
  - On req_valid & req_ready, latch op, addr, wdata and rd, then go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (exactly 1 cycle):
  - rom_address = latched addr; rom_write_data = latched wdata.
  - fault = (addr[ADDR_W-1:DEPTH_LOG2] != 0).
  - rom_read = load & !fault.
  - rom_write = store & !fault.
  - At the edge: rsp_data <= (load & !fault) ? rom_data : 0; rsp_is_load <= load; rsp_rd <= rd; rsp_fault <= fault; rsp_valid <= 1. Then go to RESP.
- Outside ACCESS: rom_read = 0, rom_write = 0, and rom_address / rom_write_data hold their latched values (no glitching to X).
- RESP:
  - Response fields are stable while rsp_valid = 1.
  - On rsp_ready = 1: clear rsp_valid and go to IDLE.
  - On rsp_ready = 0: hold all response fields and stay in RESP (backpressure).
- Latency and throughput:
  - Request accept edge to rsp_valid = 2 edges.
  - Minimum request spacing is 3 cycles; there is no accept in RESP.
- Store semantics:
  - The memory is updated at the ACCESS-exit edge.
  - A load issued after a store response sees the new value; ordering is guaranteed by the single outstanding request.
- Faulting store: memory is unmodified; the response is still produced with rsp_fault = 1.
- Reset mid-operation: rst high during ACCESS suppresses the memory write in that cycle, because rom_write is gated by !rst. The request is dropped and no response is produced.
- Width rules: addresses compare unsigned. No address arithmetic is performed; no wrap-around.

Decomposition:
- Shared package constants:
  - OP_LOAD = 1'b0, OP_STORE = 1'b1
  - state encoding ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_RESP = 2'd2
  - DATA_W / ADDR_W / DEPTH_LOG2 defaults, shared with the data memory and register file
- Single module; no sub-module. The range check is one expression and does not warrant its own block.

Test Plan:
- Reset: hold rst 2 cycles with req_valid = 1 -> rsp_valid = 0, rom_write = 0, rom_read = 0, req_ready = 0 during rst, and req_ready = 1 the cycle after rst falls.
- Load init: load addr 0x01, rd = 3 -> rom_read = 1 for exactly one cycle, then rsp_valid = 1, rsp_data = 0xFF, rsp_rd = 3, rsp_is_load = 1, rsp_fault = 0.
- Store then load: store 0xA5 to 0x04, then load 0x04 -> rom_write = 1 for one cycle with rom_address = 0x04; the load returns rsp_data = 0xA5.
- Fault: store 0x5A to 0x0C, then load 0x04 -> store response has rsp_fault = 1 and rom_write stays 0 throughout; the load returns 0xA5, not 0x5A.
- Backpressure: load 0x00 with rsp_ready = 0 for 3 cycles -> rsp_valid / rsp_data = 0x0A held stable, and req_ready = 0 during the stall. Raising rsp_ready completes the response, and req_ready = 1 the next cycle.
- Reset mid-store: store 0x77 to 0x05 with rst asserted in the ACCESS cycle -> no rom_write pulse and no response; a subsequent load of 0x05 returns 0x00.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared constants for the MEM stage, data memory and register file.
package mem_access_stage_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_DEPTH_LOG2 = 3;
  localparam int DEF_RIDX_W     = 3;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// Request (execute -> MEM) and response (MEM -> writeback) handshakes.
interface mem_access_stage_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int RIDX_W = 3
);

  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [RIDX_W-1:0] req_rd;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_is_load;
  logic [RIDX_W-1:0] rsp_rd;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_fault;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_rd, rsp_ready,
    output req_ready, rsp_valid, rsp_is_load, rsp_rd, rsp_data, rsp_fault
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_rd, rsp_ready,
    input  req_ready, rsp_valid, rsp_is_load, rsp_rd, rsp_data, rsp_fault
  );

endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: one outstanding load/store, drives the 8-entry data memory port
// and returns results to writeback; out-of-range addresses fault instead of aliasing.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int RIDX_W     = DEF_RIDX_W
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_stage_if.slave bus,
  output logic [ADDR_W-1:0] rom_address,
  output logic [DATA_W-1:0] rom_write_data,
  output logic              rom_write,
  output logic              rom_read,
  input  logic [DATA_W-1:0] rom_data
);

  state_e state_q, state_d;

  logic              op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [RIDX_W-1:0] rd_q;

  logic              rsp_valid_q;
  logic              rsp_is_load_q;
  logic              rsp_fault_q;
  logic [RIDX_W-1:0] rsp_rd_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic accept;
  logic in_access;
  logic fault;
  logic do_read;
  logic do_write;

  // Any set bit above the implemented depth would alias in the memory.
  assign fault     = (addr_q[ADDR_W-1:DEPTH_LOG2] != '0);
  assign in_access = (state_q == ST_ACCESS);
  assign do_read   = in_access && (op_q == OP_LOAD) && !fault;
  assign do_write  = in_access && (op_q == OP_STORE) && !fault;

  assign rom_address    = addr_q;
  assign rom_write_data = wdata_q;

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    bus.req_ready = 1'b0;
    rom_read      = do_read && !rst;
    rom_write     = do_write && !rst;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready = !rst;
        if (bus.req_valid && !rst) begin
          accept  = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      op_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_q          <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_is_load_q <= 1'b0;
      rsp_fault_q   <= 1'b0;
      rsp_rd_q      <= '0;
      rsp_data_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= bus.req_op;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        rd_q    <= bus.req_rd;
      end
      if (in_access) begin
        rsp_valid_q   <= 1'b1;
        rsp_is_load_q <= (op_q == OP_LOAD);
        rsp_rd_q      <= rd_q;
        rsp_fault_q   <= fault;
        rsp_data_q    <= do_read ? rom_data : '0;
      end else if ((state_q == ST_RESP) && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_is_load = rsp_is_load_q;
  assign bus.rsp_rd      = rsp_rd_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_fault   = rsp_fault_q;

endmodule
